bcd_count_ctrl: RTL and testbench

- Sequencing controller for the two-digit BCD counter datapath (load pulse, count input, 8-bit BCD count).
- Accepts commands over a valid/ready interface: clear, set target, start, stop.
- Issues prescaled count-enable pulses to the datapath until its count equals a programmed BCD target, then pulses done.
- Sits between the system control logic and the BCD datapath; the datapath only sees load and enable.

---
 rtl/bcd_ctrl_pkg.sv | 25 ++
 rtl/bcd_count_ctrl_if.sv | 23 ++
 rtl/bcd_ctrl_prescaler.sv | 26 ++
 rtl/bcd_count_ctrl.sv | 148 ++++++++++++++
 tb/tb_bcd_count_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_ctrl_pkg.sv
// rtl/bcd_ctrl_pkg.sv - shared types and constants for the BCD count controller
package bcd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETTLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  localparam logic [1:0] OP_CLEAR      = 2'b00;
  localparam logic [1:0] OP_SET_TARGET = 2'b01;
  localparam logic [1:0] OP_START      = 2'b10;
  localparam logic [1:0] OP_STOP       = 2'b11;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [7:0] TARGET_RESET  = 8'h99;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= BCD_DIGIT_MAX) && (v[3:0] <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// rtl/bcd_count_ctrl_if.sv - command valid/ready bus into the BCD count controller
interface bcd_count_ctrl_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/bcd_ctrl_prescaler.sv
// rtl/bcd_ctrl_prescaler.sv - DIV-modulo counter producing one tick per DIV enabled clocks
module bcd_ctrl_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - BCD counter sequencing controller; BCD_CTRL_WDOG_EN adds a stall watchdog
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int WDOG_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst_syn,
  bcd_count_ctrl_if.slave  cmd,
  input  logic [7:0]       bcd_q,
  output logic             bcd_load,
  output logic             bcd_en,
  output logic             busy,
  output logic             done,
  output logic             err
);

  if (DIV < 1 || DIV > 255 || WDOG_TICKS < 1 || WDOG_TICKS > 255) begin : g_param_check
    $error("bcd_count_ctrl: DIV and WDOG_TICKS must be in 1..255");
  end

  state_t     state, state_d;
  logic [7:0] target;
  logic       match, cmd_acc;
  logic       acc_clear, acc_set, acc_start, acc_stop;
  logic       wdog_trip, wdog_fire;
  logic       pre_clr, pre_en, tick;
  logic       busy_d, load_d, done_d;

  assign match         = (bcd_q == target);
  assign cmd.cmd_ready = (state == IDLE) || (state == HOLD) || ((state == RUN) && !match);
  assign cmd_acc       = cmd.cmd_valid && cmd.cmd_ready;
  assign acc_clear     = cmd_acc && (cmd.cmd_op == OP_CLEAR);
  assign acc_set       = cmd_acc && (cmd.cmd_op == OP_SET_TARGET);
  assign acc_start     = cmd_acc && (cmd.cmd_op == OP_START);
  assign acc_stop      = cmd_acc && (cmd.cmd_op == OP_STOP);

`ifdef BCD_CTRL_WDOG_EN
  logic [7:0] wdog_cnt;
  logic [7:0] bcd_q_prev;

  // Counts pulses that produced no visible change in the datapath count.
  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      wdog_cnt   <= '0;
      bcd_q_prev <= '0;
    end else begin
      bcd_q_prev <= bcd_q;
      if ((state != RUN) || (bcd_q != bcd_q_prev)) begin
        wdog_cnt <= '0;
      end else if (bcd_en && (wdog_cnt != 8'hFF)) begin
        wdog_cnt <= wdog_cnt + 8'd1;
      end
    end
  end

  assign wdog_trip = (wdog_cnt >= 8'(WDOG_TICKS));
`else
  assign wdog_trip = 1'b0;
`endif

  assign wdog_fire = (state == RUN) && !match && !cmd_acc && wdog_trip;

  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // A match in RUN wins over commands because cmd_ready is already low.
  always_comb begin
    state_d = state;
    case (state)
      IDLE, HOLD: begin
        if (acc_clear) begin
          state_d = CLR;
        end else if (acc_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (match) begin
          state_d = DONE;
        end else if (acc_clear) begin
          state_d = CLR;
        end else if (acc_stop || wdog_fire) begin
          state_d = HOLD;
        end
      end
      CLR:     state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d == CLR) || (state_d == SETTLE) || (state_d == RUN);
    load_d = (state_d == CLR);
    done_d = (state_d == DONE);
  end

  assign pre_en  = (state == RUN) && (state_d == RUN);
  assign pre_clr = (acc_start && (state != RUN)) || (acc_stop && (state == RUN));

  bcd_ctrl_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_syn),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      busy     <= 1'b0;
      bcd_load <= 1'b0;
      done     <= 1'b0;
      bcd_en   <= 1'b0;
    end else begin
      busy     <= busy_d;
      bcd_load <= load_d;
      done     <= done_d;
      bcd_en   <= tick;
    end
  end

  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      target <= TARGET_RESET;
      err    <= 1'b0;
    end else if (acc_clear) begin
      err <= 1'b0;
    end else if (acc_set) begin
      if ((state == RUN) || !bcd_valid(cmd.cmd_data)) begin
        err <= 1'b1;
      end else begin
        target <= cmd.cmd_data;
      end
    end else if (wdog_fire) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb/tb_bcd_count_ctrl.sv - self-checking bench for bcd_count_ctrl with a BCD datapath model
module tb_bcd_count_ctrl;
  import bcd_ctrl_pkg::*;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_syn = 1'b1;
  logic [7:0] bcd_q;
  logic       bcd_load, bcd_en, busy, done, err;
  logic       freeze = 1'b0;
  logic [7:0] dp_q;

  bcd_count_ctrl_if cmd_if ();

  bcd_count_ctrl #(.DIV(DIV), .WDOG_TICKS(16)) dut (
    .clk      (clk),
    .rst_syn  (rst_syn),
    .cmd      (cmd_if.slave),
    .bcd_q    (bcd_q),
    .bcd_load (bcd_load),
    .bcd_en   (bcd_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    int t, u;
    t = v / 10;
    u = v % 10;
    return {t[3:0], u[3:0]};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: registered two-digit decimal counter, reload to 00, wraps 99 -> 00.
  assign bcd_q = dp_q;
  always @(posedge clk or negedge rst_syn) begin
    if (!rst_syn)                 dp_q <= 8'h00;
    else if (bcd_load)            dp_q <= 8'h00;
    else if (bcd_en && !freeze)   dp_q <= int2bcd((bcd2int(dp_q) + 1) % 100);
  end

  int en_q[$];
  int done_q[$];
  always @(negedge clk) begin
    if (bcd_en === 1'b1) en_q.push_back(cyc);
    if (done === 1'b1)   done_q.push_back(cyc);
  end

  int         checks = 0;
  int         errors = 0;
  int         acc_cyc, n, a1, a2;
  logic [7:0] tgt, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    chk("cmd_ready_at_send", cmd_if.cmd_ready, 1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic clear_mon();
    en_q.delete();
    done_q.delete();
  endtask

  task automatic prep(input logic [7:0] t);
    send(OP_SET_TARGET, t);
    tgt = t;
    send(OP_CLEAR, 8'h00);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pulses(input int cnt, input int budget);
    int b = 0;
    while (en_q.size() < cnt && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("pulse_wait", en_q.size(), cnt);
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    while (done_q.size() < 1 && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("done_wait", done_q.size(), 1);
  endtask

  // Pulse k of a run segment is seen DIV*k cycles after the accepting edge.
  task automatic check_pulses(input string tag, input int first, input int cnt, input int base);
    int nbad = 0;
    if (en_q.size() != first + cnt) nbad++;
    for (int k = 0; k < cnt; k++) begin
      if (first + k >= en_q.size() || en_q[first + k] != base + DIV * (k + 1)) nbad++;
    end
    chk(tag, nbad, 0);
  endtask

  task automatic finish_run(input string tag, input int cnt, input int base, input int first);
    int exp_done, got_done;
    exp_done = (cnt == 0) ? base + 1 : base + DIV * cnt + 2;
    wait_done(DIV * cnt + 20);
    check_pulses({tag, "_en"}, first, cnt, base);
    got_done = (done_q.size() > 0) ? done_q[0] : -1;
    chk({tag, "_done_cyc"}, got_done, exp_done);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_ready_idle"}, cmd_if.cmd_ready, 1);
    chk({tag, "_final_q"}, bcd_q, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = 8'h00;
    #1 rst_syn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_load", bcd_load, 0);
    chk("reset_en", bcd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_ready", cmd_if.cmd_ready, 1);
    rst_syn = 1'b1;

    for (int i = 0; i < 3; i++) begin
      n = (i == 0) ? 0 : (i == 1) ? 5 : int'($urandom_range(1, 30));
      prep(int2bcd(n));
      clear_mon();
      send(OP_START, 8'h00);
      finish_run("run", n, acc_cyc, 0);
    end

    n = $urandom_range(1, 20);
    send(OP_SET_TARGET, int2bcd(n));
    tgt = int2bcd(n);
    bad = 8'($urandom);
    if (bcd_valid(bad)) bad[3:0] = 4'hA + 4'($urandom_range(0, 5));
    send(OP_SET_TARGET, bad);
    chk("err_illegal", err, 1);
    send(OP_CLEAR, 8'h00);
    @(negedge clk);
    chk("clr_load_on", bcd_load, 1);
    chk("clr_busy1", busy, 1);
    chk("clr_err", err, 0);
    @(negedge clk);
    chk("clr_load_off", bcd_load, 0);
    chk("clr_busy2", busy, 1);
    @(negedge clk);
    chk("clr_busy_off", busy, 0);
    clear_mon();
    send(OP_START, 8'h00);
    finish_run("illegal_kept", n, acc_cyc, 0);

    n = $urandom_range(5, 12);
    prep(int2bcd(n));
    clear_mon();
    send(OP_START, 8'h00);
    a1 = acc_cyc;
    wait_pulses(2, DIV * 2 + 5);
    send(OP_STOP, 8'h00);
    repeat (10) @(negedge clk);
    chk("hold_no_en", en_q.size(), 2);
    chk("hold_busy", busy, 0);
    chk("hold_count", bcd_q, 8'h02);
    send(OP_START, 8'h00);
    a2 = acc_cyc;
    send(OP_SET_TARGET, int2bcd($urandom_range(0, 99)));
    chk("err_set_in_run", err, 1);
    finish_run("resume", n - 2, a2, 2);
    chk("stop_segment", (en_q[0] == a1 + DIV) && (en_q[1] == a1 + 2 * DIV), 1);

    n = $urandom_range(2, 9);
    prep(int2bcd(n));
    clear_mon();
    send(OP_START, 8'h00);
    wait_pulses(n, DIV * n + 10);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_STOP;
    chk("match_q", bcd_q, tgt);
    chk("ready_at_match", cmd_if.cmd_ready, 0);
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("done_after_match", done, 1);
    @(negedge clk);
    chk("match_busy_idle", busy, 0);
    chk("match_ready_idle", cmd_if.cmd_ready, 1);

    prep(8'h99);
    freeze = 1'b1;
    clear_mon();
    send(OP_START, 8'h00);
    repeat (100) @(negedge clk);
`ifdef BCD_CTRL_WDOG_EN
    chk("wdog_pulses", en_q.size(), 16);
    chk("wdog_err", err, 1);
    chk("wdog_hold_busy", busy, 0);
    chk("wdog_hold_ready", cmd_if.cmd_ready, 1);
`else
    chk("frozen_pulses", en_q.size() >= 20, 1);
    chk("frozen_err", err, 0);
    chk("frozen_busy", busy, 1);
    send(OP_STOP, 8'h00);
`endif
    freeze = 1'b0;

    prep(8'h50);
    send(OP_START, 8'h00);
    repeat (10) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #1 rst_syn = 1'b0;
    #1;
    chk("midrun_load", bcd_load, 0);
    chk("midrun_en", bcd_en, 0);
    chk("midrun_busy", busy, 0);
    chk("midrun_done", done, 0);
    chk("midrun_err", err, 0);
    chk("midrun_ready", cmd_if.cmd_ready, 1);
    #2 rst_syn = 1'b1;
    send(OP_CLEAR, 8'h00);
    repeat (2) @(negedge clk);
    tgt = TARGET_RESET;
    clear_mon();
    send(OP_START, 8'h00);
    finish_run("reset_target", 99, acc_cyc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
